// File: rtl/esc_pwm_array.sv
// esc_pwm_array: N-channel ESC PWM generator with clamp, per-period slew limit, arm/disarm FSM and emergency stop
module esc_pwm_array #(
  parameter int NUM_CH      = 4,
  parameter int RATE_W      = 8,
  parameter int SCALE_SHIFT = 2,
  parameter int PERIOD_US   = 20000,
  parameter int MIN_HIGH_US = 1000,
  parameter int MAX_HIGH_US = 2000,
  parameter int MAX_STEP    = 16
) (
  input  logic                     us_clk,
  input  logic                     resetn,
  input  logic [NUM_CH*RATE_W-1:0] rate_in,
  input  logic                     arm,
  input  logic                     estop,
  output logic [NUM_CH-1:0]        pwm_out,
  output logic                     period_start,
  output logic                     armed,
  output logic                     stopped
);
  localparam int CW = $clog2(PERIOD_US);
  localparam int SW = RATE_W + 1;
  localparam int HW = RATE_W + SCALE_SHIFT + $clog2(MIN_HIGH_US + MAX_HIGH_US + 1) + 1;
  localparam logic [SW-1:0] STEP = SW'(MAX_STEP);
  typedef enum logic [1:0] {DISARMED, ARMED, STOPPED} state_t;
  state_t state, state_nx;
  logic [CW-1:0] period_cnt, cnt_nx;
  logic [RATE_W-1:0] eff_rate [NUM_CH];
  logic [RATE_W-1:0] eff_nx [NUM_CH];
  logic [CW-1:0] high_us [NUM_CH];
  logic [CW-1:0] high_nx [NUM_CH];
  logic [NUM_CH-1:0] pwm_nx;
  logic [SW-1:0] t, e;
  logic [HW-1:0] sum;
  logic wrap;
  assign wrap = period_cnt == CW'(PERIOD_US - 1);
  assign cnt_nx = wrap ? '0 : period_cnt + CW'(1);
  assign armed = state == ARMED;
  assign stopped = state == STOPPED;
  // high_us is taken from the post-wrap eff_rate so a new period uses the rate chosen at its own wrap
  always_comb begin
    state_nx = estop ? STOPPED : !wrap ? state : !arm ? DISARMED : state == STOPPED ? STOPPED : ARMED;
    eff_nx = eff_rate;
    high_nx = high_us;
    pwm_nx = '0;
    t = '0;
    e = '0;
    sum = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      t = SW'(rate_in[i*RATE_W +: RATE_W]);
      e = SW'(eff_rate[i]);
      eff_nx[i] = state_nx != ARMED ? '0 : !wrap ? eff_rate[i] : MAX_STEP == 0 ? t[RATE_W-1:0] :
                  t > e + STEP ? RATE_W'(e + STEP) : t + STEP < e ? RATE_W'(e - STEP) : t[RATE_W-1:0];
      sum = HW'(MIN_HIGH_US) + (HW'(eff_nx[i]) << SCALE_SHIFT);
      high_nx[i] = !wrap ? high_us[i] : sum > HW'(MAX_HIGH_US) ? CW'(MAX_HIGH_US) : CW'(sum);
      pwm_nx[i] = state_nx != STOPPED && cnt_nx < high_nx[i];
    end
  end
  always_ff @(posedge us_clk or negedge resetn)
    if (!resetn) begin
      state <= DISARMED;
      period_cnt <= CW'(PERIOD_US - 1);
      eff_rate <= '{default: '0};
      high_us <= '{default: '0};
      pwm_out <= '0;
      period_start <= 1'b0;
    end else begin
      state <= state_nx;
      period_cnt <= cnt_nx;
      eff_rate <= eff_nx;
      high_us <= high_nx;
      pwm_out <= pwm_nx;
      period_start <= cnt_nx == '0;
    end
endmodule
